// File: rtl/conv_layer_sequencer.sv
// ============================================================================
// Module   : conv_layer_sequencer
// Purpose  : Walks one 3x3 valid convolution layer over the local pixel,
//            weight and bias memories: per output element it reads the bias,
//            streams the kernel window into the MAC datapath, drains the
//            memory latency and writes the accumulator to result memory.
//            Raises the CPU interrupt once the whole layer is written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_layer_sequencer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int IN_CH  = 3,
    parameter int OUT_CH = 8,
    parameter int K      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        layer1_input_store_done,
    input  logic        layer1_weight_store_done,
    input  logic        layer1_bias_store_done,
    input  logic [1:0]  image_set_register_data_output,
    output logic        busy,
    output logic        pixel_rd,
    output logic [15:0] pixel_rd_addr,
    output logic        weight_rd,
    output logic [15:0] weight_rd_addr,
    output logic        bias_rd,
    output logic [15:0] bias_rd_addr,
    output logic        acc_load_bias,
    output logic        mac_en,
    output logic        result_write,
    output logic [15:0] result_addr,
    output logic        interrupt_register_write_signal,
    output logic        interrupt_register_data_in
);

    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;

    // Loop limits and address strides, all in the 16-bit address domain
    localparam logic [15:0] KX_LAST   = 16'(K - 1);
    localparam logic [15:0] IC_LAST   = 16'(IN_CH - 1);
    localparam logic [15:0] OC_LAST   = 16'(OUT_CH - 1);
    localparam logic [15:0] OCOL_LAST = 16'(OW - 1);
    localparam logic [15:0] OROW_LAST = 16'(OH - 1);
    localparam logic [15:0] PLANE_IN  = 16'(IMG_H * IMG_W);
    localparam logic [15:0] PLANE_OUT = 16'(OH * OW);
    localparam logic [15:0] ROW_IN    = 16'(IMG_W);
    localparam logic [15:0] ROW_OUT   = 16'(OW);
    localparam logic [15:0] KSIDE     = 16'(K);
    localparam logic [15:0] CH_IN     = 16'(IN_CH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BIAS  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]  state;
    logic [15:0] orow, ocol, oc, ic, ky, kx;
    logic        input_ready, weight_ready, bias_ready;
    logic        start_ok;

    assign start_ok = (image_set_register_data_output == 2'b01) &&
                      input_ready && weight_ready && bias_ready;

    // Sticky load flags; a fresh image is required for every run, so only the
    // input flag is consumed when the layer completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            input_ready  <= 1'b0;
            weight_ready <= 1'b0;
            bias_ready   <= 1'b0;
        end else begin
            if (state == ST_DONE)
                input_ready <= 1'b0;
            if (layer1_input_store_done)
                input_ready <= 1'b1;
            if (layer1_weight_store_done)
                weight_ready <= 1'b1;
            if (layer1_bias_store_done)
                bias_ready <= 1'b1;
        end
    end

    // Sequencer FSM with nested loop counters (orow > ocol > oc > ic > ky > kx)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            orow  <= '0;
            ocol  <= '0;
            oc    <= '0;
            ic    <= '0;
            ky    <= '0;
            kx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_BIAS;
                        orow  <= '0;
                        ocol  <= '0;
                        oc    <= '0;
                        ic    <= '0;
                        ky    <= '0;
                        kx    <= '0;
                    end
                end
                ST_BIAS: state <= ST_MAC;
                ST_MAC: begin
                    if (kx == KX_LAST) begin
                        kx <= '0;
                        if (ky == KX_LAST) begin
                            ky <= '0;
                            if (ic == IC_LAST) begin
                                ic    <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                ic <= ic + 16'd1;
                            end
                        end else begin
                            ky <= ky + 16'd1;
                        end
                    end else begin
                        kx <= kx + 16'd1;
                    end
                end
                ST_DRAIN: state <= ST_WRITE;
                ST_WRITE: begin
                    state <= ST_BIAS;
                    if (oc == OC_LAST) begin
                        oc <= '0;
                        if (ocol == OCOL_LAST) begin
                            ocol <= '0;
                            if (orow == OROW_LAST) begin
                                orow  <= '0;
                                state <= ST_DONE;
                            end else begin
                                orow <= orow + 16'd1;
                            end
                        end else begin
                            ocol <= ocol + 16'd1;
                        end
                    end else begin
                        oc <= oc + 16'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data returns one cycle after the strobe, so the datapath controls
    // are the read strobes delayed by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_load_bias <= 1'b0;
            mac_en        <= 1'b0;
        end else begin
            acc_load_bias <= bias_rd;
            mac_en        <= pixel_rd & weight_rd;
        end
    end

    // Strobes decode straight from state; addresses are gated to zero when idle
    always_comb begin
        busy                            = (state != ST_IDLE);
        bias_rd                         = (state == ST_BIAS);
        pixel_rd                        = (state == ST_MAC);
        weight_rd                       = (state == ST_MAC);
        result_write                    = (state == ST_WRITE);
        interrupt_register_write_signal = (state == ST_DONE);
        interrupt_register_data_in      = (state == ST_DONE);
        bias_rd_addr   = bias_rd ? oc : 16'd0;
        pixel_rd_addr  = pixel_rd ?
                         (ic * PLANE_IN + (orow + ky) * ROW_IN + (ocol + kx)) : 16'd0;
        weight_rd_addr = weight_rd ?
                         (((oc * CH_IN + ic) * KSIDE + ky) * KSIDE + kx) : 16'd0;
        result_addr    = result_write ?
                         (oc * PLANE_OUT + orow * ROW_OUT + ocol) : 16'd0;
    end

endmodule

`default_nettype wire
